// File: rtl/bcrypt_pd_loader.sv
// Streams a 30-word bcrypt job into PD (addr 0..30, constant at 18) and hands PD to the core.
// Optional iter_count range check: define BCRYPT_LOADER_ITER_CHECK_EN.
module bcrypt_pd_loader #(
   parameter int unsigned    MSB       = 31,
   parameter int unsigned    ITER_BITS = 19,
   parameter logic [MSB:0]   CONST_64  = 32'd64
) (
   input  logic         CLK,
   input  logic         reset,
   input  logic [MSB:0] din,
   input  logic         din_valid,
   output logic         din_ready,
   output logic [4:0]   PD_addr,
   output logic [MSB:0] PD_din,
   output logic         PD_wr_en,
   output logic         PD_busy,
   output logic         data_ready,
   input  logic         core_start,
   input  logic         core_idle,
   output logic         err
);

`ifdef BCRYPT_LOADER_ITER_CHECK_EN
   localparam bit CheckEn = 1'b1;
`else
   localparam bit CheckEn = 1'b0;
`endif

   localparam logic [4:0] LastEkWord = 5'd17;
   localparam logic [4:0] IterWord   = 5'd18;
   localparam logic [4:0] ConstAddr  = 5'd18;
   localparam logic [4:0] LastWord   = 5'd29;

   typedef enum logic [1:0] {StLoad, StConst, StReady, StRun} state_e;

   state_e     state_q;
   logic [4:0] wcnt_q;
   logic       err_flag_q;
   logic       err_q;
   logic       data_ready_q;
   logic       busy_q;

   logic       accept;
   logic       iter_bad;

   // iter_count must be non-zero and fit in the core's ITER_BITS-wide setting.
   assign iter_bad = (din == '0) || ((din >> ITER_BITS) != '0);

   // Write path is combinational so a word reaches PD in the cycle it is accepted.
   always_comb begin
      din_ready = 1'b0;
      accept    = 1'b0;
      PD_wr_en  = 1'b0;
      PD_addr   = '0;
      PD_din    = '0;
      if (!reset) begin
         unique case (state_q)
            StLoad: begin
               din_ready = 1'b1;
               accept    = din_valid;
               PD_wr_en  = din_valid;
               PD_addr   = (wcnt_q > LastEkWord) ? wcnt_q + 5'd1 : wcnt_q;
               PD_din    = din;
            end
            StConst: begin
               PD_wr_en = 1'b1;
               PD_addr  = ConstAddr;
               PD_din   = CONST_64;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         state_q      <= StLoad;
         wcnt_q       <= '0;
         err_flag_q   <= 1'b0;
         err_q        <= 1'b0;
         data_ready_q <= 1'b0;
         busy_q       <= 1'b1;
      end else begin
         err_q <= 1'b0;
         unique case (state_q)
            StLoad: begin
               if (accept) begin
                  if (CheckEn && wcnt_q == IterWord && iter_bad) begin
                     err_flag_q <= 1'b1;
                  end
                  if (wcnt_q == LastEkWord) begin
                     state_q <= StConst;
                     wcnt_q  <= wcnt_q + 5'd1;
                  end else if (wcnt_q == LastWord) begin
                     wcnt_q <= '0;
                     if (err_flag_q) begin
                        // Rejected job: stay in LOAD and wait for the next stream.
                        err_q      <= 1'b1;
                        err_flag_q <= 1'b0;
                     end else begin
                        state_q      <= StReady;
                        data_ready_q <= 1'b1;
                        busy_q       <= 1'b0;
                     end
                  end else begin
                     wcnt_q <= wcnt_q + 5'd1;
                  end
               end
            end
            StConst: begin
               state_q <= StLoad;
               wcnt_q  <= IterWord;
            end
            StReady: begin
               if (core_start) begin
                  state_q      <= StRun;
                  data_ready_q <= 1'b0;
               end
            end
            StRun: begin
               if (core_idle) begin
                  state_q <= StLoad;
                  wcnt_q  <= '0;
                  busy_q  <= 1'b1;
               end
            end
            default: state_q <= StLoad;
         endcase
      end
   end

   assign PD_busy    = busy_q | reset;
   assign data_ready = data_ready_q & ~reset;
   assign err        = err_q & ~reset;

endmodule

// File: tb/tb_bcrypt_pd_loader.sv
// Self-checking bench for bcrypt_pd_loader: vector table for one job plus directed sequences.
module tb_bcrypt_pd_loader;

   logic        CLK = 1'b0;
   logic        reset;
   logic [31:0] din;
   logic        din_valid;
   logic        din_ready;
   logic [4:0]  PD_addr;
   logic [31:0] PD_din;
   logic        PD_wr_en;
   logic        PD_busy;
   logic        data_ready;
   logic        core_start;
   logic        core_idle;
   logic        err;

   always #5 CLK = ~CLK;

   bcrypt_pd_loader dut (
      .CLK        (CLK),
      .reset      (reset),
      .din        (din),
      .din_valid  (din_valid),
      .din_ready  (din_ready),
      .PD_addr    (PD_addr),
      .PD_din     (PD_din),
      .PD_wr_en   (PD_wr_en),
      .PD_busy    (PD_busy),
      .data_ready (data_ready),
      .core_start (core_start),
      .core_idle  (core_idle),
      .err        (err)
   );

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] pd_mem [32];
   int          wr_cnt [32];
   int          gap_wr;
   int          err_seen;

   typedef struct {
      logic        dv;
      logic [31:0] d;
      logic        cs;
      logic        ci;
      logic [41:0] exp;
   } vec_t;

   vec_t vt [48];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [41:0] pack(input logic dr, input logic we, input logic [4:0] a,
                                        input logic [31:0] d, input logic rdy, input logic busy,
                                        input logic e);
      return {dr, we, we ? a : 5'd0, we ? d : 32'd0, rdy, busy, e};
   endfunction

   function automatic logic [41:0] observed();
      return pack(din_ready, PD_wr_en, PD_addr, PD_din, data_ready, PD_busy, err);
   endfunction

   task automatic drive();
      @(posedge CLK);
      #1;
   endtask

   // All output sampling and PD shadowing happens here, on the falling edge.
   task automatic sample();
      @(negedge CLK);
      if (PD_wr_en) begin
         pd_mem[PD_addr] = PD_din;
         wr_cnt[PD_addr]++;
         if (!din_valid && PD_addr != 5'd18) gap_wr++;
      end
      if (err) err_seen++;
   endtask

   task automatic clear_pd();
      for (int a = 0; a < 32; a++) begin
         pd_mem[a] = '0;
         wr_cnt[a] = 0;
      end
      gap_wr = 0;
   endtask

   task automatic check_pd(input string tag, input logic [31:0] base, input logic [31:0] iter);
      logic [31:0] e;
      logic [7:0]  c;
      for (int a = 0; a < 31; a++) begin
         if (a < 18)       e = base + 32'(a);
         else if (a == 18) e = 32'd64;
         else if (a == 19) e = iter;
         else              e = base + 32'(a - 1);
         c = wr_cnt[a][7:0];
         chk($sformatf("%s_pd%0d", tag, a), {c, pd_mem[a]}, {8'd1, e});
      end
   endtask

   // Streams one job; returns after sampling the cycle following the last accept.
   task automatic send_job(input string tag, input logic [31:0] base, input logic [31:0] iter,
                           input bit gaps);
      int  i = 0;
      int  budget = 0;
      int  early = 0;
      bit  tog = 1'b0;
      while (i < 30 && budget < 400) begin
         drive();
         if (gaps && tog) begin
            din_valid = 1'b0;
         end else begin
            din_valid = 1'b1;
            din       = (i == 18) ? iter : base + 32'(i);
         end
         tog = ~tog;
         sample();
         if (data_ready) early++;
         if (din_valid && din_ready) i++;
         budget++;
      end
      chk({tag, "_accepts"}, 64'(i), 64'd30);
      chk({tag, "_dr_early"}, 64'(early), 64'd0);
      drive();
      din_valid = 1'b0;
      sample();
   endtask

   task automatic handshake(input string tag);
      drive();
      core_start = 1'b1;
      sample();
      drive();
      core_start = 1'b0;
      sample();
      chk({tag, "_run"}, {data_ready, PD_busy, din_ready}, 3'b000);
      drive();
      core_idle = 1'b1;
      sample();
      drive();
      core_idle = 1'b0;
      sample();
      chk({tag, "_reload"}, {PD_busy, din_ready, data_ready}, 3'b110);
   endtask

   initial begin
      reset      = 1'b1;
      din        = '0;
      din_valid  = 1'b0;
      core_start = 1'b0;
      core_idle  = 1'b0;
      err_seen   = 0;
      clear_pd();

      for (int k = 0; k < 48; k++) begin
         vt[k].dv = 1'b0;
         vt[k].d  = '0;
         vt[k].cs = 1'b0;
         vt[k].ci = 1'b0;
         if (k < 18) begin
            vt[k].dv  = 1'b1;
            vt[k].d   = 32'h100 + 32'(k);
            vt[k].exp = pack(1'b1, 1'b1, 5'(k), 32'h100 + 32'(k), 1'b0, 1'b1, 1'b0);
         end else if (k == 18) begin
            vt[k].dv  = 1'b1;
            vt[k].d   = 32'h112;
            vt[k].exp = pack(1'b0, 1'b1, 5'd18, 32'd64, 1'b0, 1'b1, 1'b0);
         end else if (k < 31) begin
            vt[k].dv  = 1'b1;
            vt[k].d   = 32'h100 + 32'(k - 1);
            vt[k].exp = pack(1'b1, 1'b1, 5'(k), 32'h100 + 32'(k - 1), 1'b0, 1'b1, 1'b0);
         end else if (k < 42) begin
            vt[k].cs  = (k == 41);
            vt[k].exp = pack(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0);
         end else if (k < 47) begin
            vt[k].ci  = (k == 46);
            vt[k].exp = pack(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);
         end else begin
            vt[k].exp = pack(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0);
         end
      end

      // Reset behaviour
      repeat (2) sample();
      chk("in_reset", {PD_wr_en, data_ready, err, PD_busy}, 4'b0001);
      drive();
      reset = 1'b0;
      sample();
      chk("after_reset", {din_ready, PD_wr_en, data_ready, err, PD_busy}, 5'b10001);

      // Back-to-back job through READY/RUN, cycle by cycle
      clear_pd();
      for (int k = 0; k < 48; k++) begin
         drive();
         din_valid  = vt[k].dv;
         din        = vt[k].d;
         core_start = vt[k].cs;
         core_idle  = vt[k].ci;
         sample();
         chk($sformatf("vec%0d", k), 64'(observed()), 64'(vt[k].exp));
      end
      core_start = 1'b0;
      core_idle  = 1'b0;
      check_pd("b2b", 32'h100, 32'h112);

      // Same stream with din_valid toggling
      clear_pd();
      send_job("gap", 32'h100, 32'h112, 1'b1);
      chk("gap_ready", {data_ready, err}, 2'b10);
      check_pd("gap", 32'h100, 32'h112);
      chk("gap_nowrite", 64'(gap_wr), 64'd0);
      handshake("gap");

      // Two further jobs
      clear_pd();
      send_job("j2", 32'h200, 32'h212, 1'b0);
      chk("j2_ready", {data_ready, err}, 2'b10);
      check_pd("j2", 32'h200, 32'h212);
      handshake("j2");
      clear_pd();
      send_job("j3", 32'h300, 32'h312, 1'b0);
      chk("j3_ready", {data_ready, err}, 2'b10);
      check_pd("j3", 32'h300, 32'h312);
      handshake("j3");

      // Reset after 10 accepted words, then a fresh job
      for (int i = 0; i < 10; i++) begin
         drive();
         din_valid = 1'b1;
         din       = 32'hDEAD0000 + 32'(i);
         sample();
      end
      drive();
      din_valid = 1'b0;
      reset     = 1'b1;
      sample();
      chk("mid_reset", {PD_wr_en, data_ready, PD_busy}, 3'b001);
      drive();
      reset = 1'b0;
      sample();
      chk("mid_after", {din_ready, data_ready, PD_busy}, 3'b101);
      clear_pd();
      send_job("rst", 32'h400, 32'h412, 1'b0);
      chk("rst_ready", {data_ready, err}, 2'b10);
      check_pd("rst", 32'h400, 32'h412);
      handshake("rst");

      // iter_count range check
      clear_pd();
      send_job("it0", 32'h500, 32'h0, 1'b0);
      check_pd("it0", 32'h500, 32'h0);
`ifdef BCRYPT_LOADER_ITER_CHECK_EN
      chk("it0_out", {data_ready, err}, 2'b01);
      drive();
      sample();
      chk("it0_after", {err, din_ready, data_ready}, 3'b010);
      send_job("ithi", 32'h500, 32'h80000, 1'b0);
      chk("ithi_out", {data_ready, err}, 2'b01);
      drive();
      sample();
      chk("ithi_after", {err, din_ready, data_ready}, 3'b010);
`else
      chk("it0_out", {data_ready, err}, 2'b10);
      handshake("it0");
      send_job("ithi", 32'h500, 32'h80000, 1'b0);
      chk("ithi_out", {data_ready, err}, 2'b10);
      handshake("ithi");
`endif
      send_job("itok", 32'h500, 32'h7FFFF, 1'b0);
      chk("itok_out", {data_ready, err}, 2'b10);
      handshake("itok");

      // core_start and core_idle together in READY
      send_job("both", 32'h600, 32'h612, 1'b0);
      chk("both_ready", {data_ready, err}, 2'b10);
      drive();
      core_start = 1'b1;
      core_idle  = 1'b1;
      sample();
      drive();
      core_start = 1'b0;
      sample();
      chk("both_run", {data_ready, PD_busy, din_ready}, 3'b000);
      drive();
      core_idle = 1'b0;
      sample();
      chk("both_load", {PD_busy, din_ready, data_ready}, 3'b110);

`ifdef BCRYPT_LOADER_ITER_CHECK_EN
      chk("err_pulses", 64'(err_seen), 64'd2);
`else
      chk("err_pulses", 64'(err_seen), 64'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
